// File: rtl/logic_op_checker.sv
// Self-test engine for a two-input logic-operator block: sweeps all four input
// vectors for ROUNDS rounds, compares both responses and reports errors.
module logic_op_checker #(
  parameter int SETTLE  = 2,
  parameter int ROUNDS  = 1,
  parameter bit EXP1_OP = 1'b0,
  parameter bit EXP2_OP = 1'b1,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             stim1,
  output logic             stim2,
  input  logic             resp1,
  input  logic             resp2,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [1:0]       first_err_vec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_FINISH
  } state_t;

  state_t     state, state_next;
  logic [3:0] settle_cnt;
  logic [1:0] vec;
  logic [7:0] round;
  logic       exp1, exp2;
  logic       mismatch;
  logic       last_vec;
  logic       settle_end;
  logic [1:0] vec_next;

  assign exp1       = EXP1_OP ? (stim1 | stim2) : (stim1 & stim2);
  assign exp2       = EXP2_OP ? (stim1 | stim2) : (stim1 & stim2);
  assign mismatch   = (resp1 != exp1) || (resp2 != exp2);
  assign last_vec   = (vec == 2'd3) && (round == 8'(ROUNDS - 1));
  assign settle_end = (settle_cnt == 4'(SETTLE - 1));
  assign vec_next   = vec + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE:   if (start) state_next = S_SETTLE;
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_end) state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        busy       = 1'b1;
        state_next = last_vec ? S_FINISH : S_SETTLE;
      end
      S_FINISH: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  // Stimulus, sweep position and result registers; reset also clears results
  // so an aborted run never reports a pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt      <= 4'd0;
      vec             <= 2'd0;
      round           <= 8'd0;
      stim1           <= 1'b0;
      stim2           <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= 2'b00;
      pass            <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            settle_cnt      <= 4'd0;
            vec             <= 2'd0;
            round           <= 8'd0;
            stim1           <= 1'b0;
            stim2           <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 2'b00;
            pass            <= 1'b0;
          end
        end
        S_SETTLE: settle_cnt <= settle_cnt + 4'd1;
        S_SAMPLE: begin
          if (mismatch) begin
            if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_vec   <= {stim1, stim2};
            end
          end
          if (last_vec) begin
            // the final vector's outcome is not yet in err_count
            pass  <= (err_count == '0) && !mismatch;
            stim1 <= 1'b0;
            stim2 <= 1'b0;
          end else begin
            vec        <= vec_next;
            stim1      <= vec_next[1];
            stim2      <= vec_next[0];
            settle_cnt <= 4'd0;
            if (vec == 2'd3) round <= round + 8'd1;
          end
        end
        S_FINISH: begin
          stim1 <= 1'b0;
          stim2 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_checker.sv
// Directed bench for logic_op_checker: four instances with different
// parameters and responder models share one clock and reset.
module tb_logic_op_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start [4];
  logic       busy [4], done [4], pass [4];
  logic       s1 [4], s2 [4], r1 [4], r2 [4];
  logic       fev_v [4];
  logic [1:0] fev [4];
  logic [7:0] ec [4];
  logic [1:0] ec3;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  // responders: 0 = correct AND/OR, 1 = all-AND, 2/3 = stuck at 0
  assign r1[0] = s1[0] & s2[0];
  assign r2[0] = s1[0] | s2[0];
  assign r1[1] = s1[1] & s2[1];
  assign r2[1] = s1[1] & s2[1];
  assign r1[2] = 1'b0;
  assign r2[2] = 1'b0;
  assign r1[3] = 1'b0;
  assign r2[3] = 1'b0;
  assign ec[3] = {6'd0, ec3};

  logic_op_checker u0 (.clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]),
    .done(done[0]), .pass(pass[0]), .stim1(s1[0]), .stim2(s2[0]), .resp1(r1[0]),
    .resp2(r2[0]), .err_count(ec[0]), .first_err_valid(fev_v[0]), .first_err_vec(fev[0]));

  logic_op_checker #(.EXP2_OP(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .start(start[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .stim1(s1[1]), .stim2(s2[1]),
    .resp1(r1[1]), .resp2(r2[1]), .err_count(ec[1]), .first_err_valid(fev_v[1]),
    .first_err_vec(fev[1]));

  logic_op_checker #(.ROUNDS(3)) u2 (.clk(clk), .rst_n(rst_n), .start(start[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .stim1(s1[2]), .stim2(s2[2]),
    .resp1(r1[2]), .resp2(r2[2]), .err_count(ec[2]), .first_err_valid(fev_v[2]),
    .first_err_vec(fev[2]));

  logic_op_checker #(.ERR_W(2), .ROUNDS(4)) u3 (.clk(clk), .rst_n(rst_n), .start(start[3]),
    .busy(busy[3]), .done(done[3]), .pass(pass[3]), .stim1(s1[3]), .stim2(s2[3]),
    .resp1(r1[3]), .resp2(r2[3]), .err_count(ec3), .first_err_valid(fev_v[3]),
    .first_err_vec(fev[3]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse start on instance i and wait for done; cycles = -1 on timeout.
  task automatic run(input int i, input int budget, output int cycles);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
    cycles = 1;
    while (!done[i] && cycles < budget) begin
      tick();
      cycles++;
    end
    if (!done[i]) cycles = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) start[i] = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({busy[i], done[i], pass[i], s1[i], s2[i], fev_v[i], fev[i]} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_flags[%0d]: got %b expected 00000000", i,
                 {busy[i], done[i], pass[i], s1[i], s2[i], fev_v[i], fev[i]});
      end
      n_checks++;
      if (ec[i] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_err_count[%0d]: got %0d expected 0", i, ec[i]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_and_or;
    logic [1:0] ev;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      ev = 2'((c - 1) / 3);
      n_checks++;
      if ({s1[0], s2[0]} !== ev) begin
        n_fail++;
        $display("FAIL andor_stim cycle %0d: got %b expected %b", c, {s1[0], s2[0]}, ev);
      end
      n_checks++;
      if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL andor_busy cycle %0d: got busy=%b done=%b expected busy=1 done=0",
                 c, busy[0], done[0]);
      end
      tick();
    end
    n_checks++;
    if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL andor_done cycle 13: got done=%b busy=%b expected done=1 busy=0",
               done[0], busy[0]);
    end
    n_checks++;
    if (pass[0] !== 1'b1 || ec[0] !== 8'd0 || fev_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL andor_result: got pass=%b err=%0d fev_v=%b expected 1 0 0",
               pass[0], ec[0], fev_v[0]);
    end
    tick();
    n_checks++;
    if (done[0] !== 1'b0 || {s1[0], s2[0]} !== 2'b00) begin
      n_fail++;
      $display("FAIL andor_after: got done=%b stim=%b expected 0 00", done[0], {s1[0], s2[0]});
    end
    repeat (3) tick();
    n_checks++;
    if (pass[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL andor_pass_hold: got %b expected 1", pass[0]);
    end
  endtask

  task automatic test_and_only;
    int cyc;
    run(1, 40, cyc);
    n_checks++;
    if (cyc !== 13) begin
      n_fail++;
      $display("FAIL andonly_done_cycle: got %0d expected 13", cyc);
    end
    n_checks++;
    if (ec[1] !== 8'd2 || fev[1] !== 2'b01 || fev_v[1] !== 1'b1 || pass[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL andonly_result: got err=%0d fev=%b fev_v=%b pass=%b expected 2 01 1 0",
               ec[1], fev[1], fev_v[1], pass[1]);
    end
  endtask

  task automatic test_stuck_rounds;
    int cyc;
    run(2, 100, cyc);
    n_checks++;
    if (cyc !== 37) begin
      n_fail++;
      $display("FAIL stuck_done_cycle: got %0d expected 37", cyc);
    end
    n_checks++;
    if (ec[2] !== 8'd9 || fev[2] !== 2'b01 || pass[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_result: got err=%0d fev=%b pass=%b expected 9 01 0",
               ec[2], fev[2], pass[2]);
    end
  endtask

  task automatic test_saturate;
    int         cyc;
    logic [1:0] prev;
    bit         wrapped;
    wrapped = 1'b0;
    start[3] = 1'b1;
    tick();
    start[3] = 1'b0;
    cyc = 1;
    prev = ec3;
    while (!done[3] && cyc < 100) begin
      tick();
      cyc++;
      if (ec3 < prev) wrapped = 1'b1;
      prev = ec3;
    end
    n_checks++;
    if (cyc !== 49 || !done[3]) begin
      n_fail++;
      $display("FAIL sat_done_cycle: got %0d expected 49", cyc);
    end
    n_checks++;
    if (wrapped !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_wrap: got wrap=%b expected 0", wrapped);
    end
    n_checks++;
    if (ec3 !== 2'd3) begin
      n_fail++;
      $display("FAIL sat_err_count: got %0d expected 3", ec3);
    end
  endtask

  task automatic test_start_ignored;
    int cyc;
    int extra;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    cyc = 3;
    while (!done[0] && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== 13 || !done[0]) begin
      n_fail++;
      $display("FAIL ign_settle_done_cycle: got %0d expected 13", cyc);
    end
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      if (done[0] || busy[0]) extra++;
      tick();
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL ign_finish_restart: got %0d active cycles expected 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    start[1] = 1'b1;
    tick();
    cyc = 1;
    while (!done[1] && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== 13 || !done[1]) begin
      n_fail++;
      $display("FAIL b2b_first_done: got %0d expected 13", cyc);
    end
    tick();
    n_checks++;
    if (busy[1] !== 1'b0 || done[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: got busy=%b done=%b expected 0 0", busy[1], done[1]);
    end
    tick();
    start[1] = 1'b0;
    n_checks++;
    if (busy[1] !== 1'b1 || ec[1] !== 8'd0 || fev_v[1] !== 1'b0 || pass[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_restart_clear: got busy=%b err=%0d fev_v=%b pass=%b expected 1 0 0 0",
               busy[1], ec[1], fev_v[1], pass[1]);
    end
    cyc = 1;
    while (!done[1] && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== 13 || ec[1] !== 8'd2) begin
      n_fail++;
      $display("FAIL b2b_second_run: got cycle=%0d err=%0d expected 13 2", cyc, ec[1]);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int cyc;
    int extra;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy[0], done[0], pass[0], s1[0], s2[0], fev_v[0]} !== 6'd0 || ec[0] !== 8'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %b err=%0d expected 000000 0",
               {busy[0], done[0], pass[0], s1[0], s2[0], fev_v[0]}, ec[0]);
    end
    tick();
    rst_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      if (done[0] || busy[0]) extra++;
      tick();
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL midrst_no_done: got %0d active cycles expected 0", extra);
    end
    run(0, 40, cyc);
    n_checks++;
    if (cyc !== 13 || pass[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_rerun: got cycle=%0d pass=%b expected 13 1", cyc, pass[0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_and_or();
    test_and_only();
    test_stuck_rounds();
    test_saturate();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
